instruction_fetch_unit: RTL

Fetch stage in front of the program ROM. Owns the program counter, drives the ROM byte address and absorbs the ROM's one-cycle registered read latency. Presents a valid/stall-qualified instruction word with its PC to the decode stage, and takes branch/jump redirects from downstream.

---
 rtl/instruction_fetch_unit.sv | 99 +++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, hides the ROM's one-cycle read latency and hands
// decode a valid/stall-qualified instruction with its PC and link value.
module instruction_fetch_unit #(
  parameter int                     PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC  = '0,
  parameter int                     ROM_BYTES = 1024
) (
  input  logic                clock,
  input  logic                reset_n,
  output logic [PC_WIDTH-1:0] rom_address,
  input  logic [32:0]         rom_instruction,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                if_valid,
  output logic [31:0]         if_instruction,
  output logic [PC_WIDTH-1:0] if_pc,
  output logic [PC_WIDTH-1:0] if_pc_plus4,
  output logic                fault
);

  localparam logic [PC_WIDTH-1:0] ROM_MASK  = PC_WIDTH'(ROM_BYTES - 1);
  localparam logic [PC_WIDTH-1:0] WORD_STEP = PC_WIDTH'(4);

  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] next_pc;
  logic [PC_WIDTH-1:0] redirect_target;
  logic                bad_redirect;
  logic                accept;

  logic                resp_valid;
  logic [PC_WIDTH-1:0] resp_pc;
  logic                skid_valid;
  logic [PC_WIDTH-1:0] skid_pc;
  logic [31:0]         skid_instr;

  // The ROM's parity/spare bit carries nothing the fetch stage needs.
  logic unused_rom_bit;
  assign unused_rom_bit = rom_instruction[32];

  assign rom_address     = pc;
  assign accept          = !stall || !if_valid;
  assign next_pc         = (pc + WORD_STEP) & ROM_MASK;
  assign redirect_target = redirect_pc & ROM_MASK & ~PC_WIDTH'(3);
  assign bad_redirect    = (redirect_pc[1:0] != 2'b00) ||
                           ((redirect_pc & ~ROM_MASK) != '0);

  // Redirect beats everything; otherwise either advance (skid first, then the
  // live ROM response) or hold and park the in-flight response in the skid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc             <= RESET_PC;
      resp_valid     <= 1'b0;
      resp_pc        <= '0;
      skid_valid     <= 1'b0;
      skid_pc        <= '0;
      skid_instr     <= '0;
      if_valid       <= 1'b0;
      if_instruction <= '0;
      if_pc          <= '0;
      if_pc_plus4    <= '0;
      fault          <= 1'b0;
    end else if (redirect_valid) begin
      pc         <= redirect_target;
      resp_valid <= 1'b0;
      skid_valid <= 1'b0;
      if_valid   <= 1'b0;
      if (bad_redirect) begin
        fault <= 1'b1;
      end
    end else if (accept) begin
      if (skid_valid) begin
        if_valid       <= 1'b1;
        if_instruction <= skid_instr;
        if_pc          <= skid_pc;
        if_pc_plus4    <= skid_pc + WORD_STEP;
      end else if (resp_valid) begin
        if_valid       <= 1'b1;
        if_instruction <= rom_instruction[31:0];
        if_pc          <= resp_pc;
        if_pc_plus4    <= resp_pc + WORD_STEP;
      end else begin
        if_valid <= 1'b0;
      end
      skid_valid <= 1'b0;
      resp_valid <= 1'b1;
      resp_pc    <= pc;
      pc         <= next_pc;
    end else begin
      if (resp_valid && !skid_valid) begin
        skid_valid <= 1'b1;
        skid_pc    <= resp_pc;
        skid_instr <= rom_instruction[31:0];
      end
      resp_valid <= 1'b0;
    end
  end

endmodule
